residue_unpacker: RTL and testbench
===================================

RESIDUE_UNPACKER -- requirements
Module: residue_unpacker

Interface
- REQ-001 Parameters: none; all widths are fixed (32-bit input word, 32 symbols, 8-bit symbols, 256-bit line).
- REQ-002 clk  input  1  single clock; all state updates on rising edge.
- REQ-003 rst  input  1  asynchronous, active-high reset.
- REQ-004 in_valid  input  1  compressed word valid.
- REQ-005 in_data  input  32  compressed stream word, MSB first.
- REQ-006 in_ready  output  1  block accepts in_data this cycle.
- REQ-007 diff_valid  output  1  diff_o holds a complete line.
- REQ-008 diff_o  output  256  32 residue bytes; symbol 0 in [255:248], symbol k in [255-8k:248-8k]; feeds the detransformer diff input.
- REQ-009 diff_ready  input  1  downstream accepts diff_o.
- REQ-010 err_o  output  1  sticky illegal-header flag.

Function
- REQ-011 Line format: 4-bit width code W in bits [31:28] of the first (header) word, then 32 symbols of W bits each, packed MSB-first contiguously across words; the remainder of the last word is padding and is ignored.
- REQ-012 Legal W = 0..8; a line occupies exactly W+1 words; every line starts on a word boundary.
- REQ-013 Word transfer occurs only on a cycle with in_valid && in_ready; line transfer occurs only on a cycle with diff_valid && diff_ready.
- REQ-014 FSM states: HDR (await header), COLLECT (await remaining W words), OUT (present line).
- REQ-015 HDR: in_ready=1; on a transfer with legal W: W=0 -> OUT, else -> COLLECT with remaining-count=W.
- REQ-016 HDR, W in 9..15: err_o set, word discarded, state stays HDR, no diff_valid produced.
- REQ-017 COLLECT: in_ready=1; each transfer appends the word to a 288-bit MSB-aligned buffer and decrements the count; on the transfer that brings the count to 0 -> OUT.
- REQ-018 OUT: in_ready=0, diff_valid=1, diff_o registered and stable until the line transfer; on the line transfer -> HDR, in_ready=1 from the next cycle.
- REQ-019 Latency: diff_valid rises the cycle after the last word transfer; minimum cost per line is W+2 cycles.
- REQ-020 Symbol k = buffer bits starting (4 + k*W) bits from the buffer MSB; W<8 -> two's-complement sign-extended to 8 bits; W=8 -> used as is; W=0 -> 8'h00.
- REQ-021 in_valid deasserted mid-line: the block holds its state and count indefinitely; there is no timeout.
- REQ-022 diff_ready asserted while diff_valid=0 has no effect; in_data is ignored whenever in_ready=0.
- REQ-023 err_o is cleared only by rst.

Reset
- REQ-024 While rst is asserted: state=HDR, count=0, buffer=0, diff_o=0, diff_valid=0, err_o=0, in_ready=0.
- REQ-025 in_ready=1 from the first clock edge after rst deasserts.
- REQ-026 rst mid-COLLECT or mid-OUT discards the partial or pending line; the next accepted word is treated as a header.

Verification
- REQ-027 W=0: single word 32'h0000_0000 -> diff_valid=1 next cycle, diff_o=256'h0.
- REQ-028 W=1: words 32'h1FFF_FFFF, 32'hF000_0000 -> all 32 bytes 8'hFF.
- REQ-029 W=8: 9-word stream encoding bytes 8'h00..8'h1F -> diff_o=256'h0001_0203_..._1E1F; diff_valid 1 cycle after the 9th transfer.
- REQ-030 W=4: symbols 4'h7 and 4'h8 alternating -> diff_o bytes alternate 8'h07, 8'hF8.
- REQ-031 Backpressure: diff_ready=0 for 5 cycles in OUT -> diff_o stable, in_ready=0 throughout; release -> HDR next cycle.
- REQ-032 Header 32'hC000_0000 (W=12) -> err_o=1, no diff_valid, next word decoded as a header; then rst pulse mid-COLLECT -> all outputs at reset values, next word taken as a header.

Source files
------------

// File: rtl/residue_unpacker_if.sv
// Purpose: bundles the compressed-word input stream, the decoded residue-line
//          output stream and the sticky error flag of residue_unpacker.
// Ports:   in_valid/in_data/in_ready (word stream), diff_valid/diff_o/diff_ready
//          (line stream), err_o (illegal-header flag).
//          Modport slave is the unpacker side; modport master is the side that
//          feeds words and consumes lines.
interface residue_unpacker_if;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_ready;
    logic         diff_valid;
    logic [255:0] diff_o;
    logic         diff_ready;
    logic         err_o;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output diff_valid,
        output diff_o,
        input  diff_ready,
        output err_o
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  diff_valid,
        input  diff_o,
        output diff_ready,
        input  err_o
    );
endinterface

// File: rtl/residue_unpacker.sv
// Purpose: unpacks one line of 32 variable-width (W = 0..8 bit) residues from
//          W+1 32-bit words into 32 sign-extended bytes.
// Latency/backpressure: diff_valid rises the cycle after the last word transfer;
//          while a line is presented, in_ready is low until diff_ready takes it.
// Ports:   clk, rst (async, active high); bus (residue_unpacker_if.slave):
//          in_valid/in_data/in_ready, diff_valid/diff_o/diff_ready, err_o.
module residue_unpacker (
    input  logic                  clk,
    input  logic                  rst,
    residue_unpacker_if.slave     bus
);

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        COLLECT = 2'd1,
        OUT     = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;          // words still to collect
    logic [3:0]    w_q, w_nxt;            // width code of the line in flight
    logic [287:0]  line_buf, buf_nxt;     // MSB-aligned concatenation of the line's words
    logic [255:0]  diff_q, line_nxt;
    logic          err_q;
    logic          err_set;
    logic          load_line;
    logic          rdy_en;                // holds in_ready low during reset
    logic          in_xfer;
    logic [3:0]    hdr_w;
    int            word_idx;

    // Extract the 32 symbols from a complete line buffer. Symbol k starts
    // 4 + k*W bits below the buffer MSB; an 8-bit window taken there and
    // arithmetically shifted right by 8-W gives the sign-extended value.
    function automatic logic [255:0] decode_line(input logic [287:0] b,
                                                 input logic [3:0]   w);
        logic [255:0] line;
        logic [7:0]   raw;
        int           base;
        line = '0;
        for (int k = 0; k < 32; k++) begin
            base = 283 - k * int'(w);
            raw  = b[base -: 8];
            if (w == 4'd0)
                line[255 - 8*k -: 8] = 8'h00;
            else
                line[255 - 8*k -: 8] = $signed(raw) >>> (4'd8 - w);
        end
        return line;
    endfunction

    assign bus.in_ready   = rdy_en && (state != OUT);
    assign bus.diff_valid = (state == OUT);
    assign bus.diff_o     = diff_q;
    assign bus.err_o      = err_q;

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign hdr_w    = bus.in_data[31:28];
    assign line_nxt = decode_line(buf_nxt, w_nxt);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        w_nxt     = w_q;
        buf_nxt   = line_buf;
        err_set   = 1'b0;
        load_line = 1'b0;
        // Position of the next COLLECT word: header is word 0.
        word_idx  = int'(w_q) - int'(cnt) + 1;

        case (state)
            HDR: begin
                if (in_xfer) begin
                    if (hdr_w > 4'd8) begin
                        // Illegal width: drop the word and keep hunting for a header.
                        err_set = 1'b1;
                    end else begin
                        w_nxt   = hdr_w;
                        buf_nxt = {bus.in_data, 256'h0};
                        cnt_nxt = hdr_w;
                        if (hdr_w == 4'd0) begin
                            state_nxt = OUT;
                            load_line = 1'b1;
                        end else begin
                            state_nxt = COLLECT;
                        end
                    end
                end
            end
            COLLECT: begin
                if (in_xfer) begin
                    for (int i = 1; i < 9; i++) begin
                        if (i == word_idx)
                            buf_nxt[287 - 32*i -: 32] = bus.in_data;
                    end
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state_nxt = OUT;
                        load_line = 1'b1;
                    end
                end
            end
            OUT: begin
                if (bus.diff_ready)
                    state_nxt = HDR;
            end
            default: begin
                state_nxt = HDR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HDR;
            cnt      <= 4'd0;
            w_q      <= 4'd0;
            line_buf <= '0;
            diff_q   <= '0;
            err_q    <= 1'b0;
            rdy_en   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            w_q      <= w_nxt;
            line_buf <= buf_nxt;
            rdy_en   <= 1'b1;
            if (load_line)
                diff_q <= line_nxt;
            if (err_set)
                err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_residue_unpacker.sv
module tb_residue_unpacker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    residue_unpacker_if intf();

    residue_unpacker dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] got,
                             input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one word, waits (bounded) for in_ready, completes the transfer.
    // Entered and left #1 after a rising edge.
    task automatic send_word(input logic [31:0] w);
        int n = 0;
        intf.in_valid = 1'b1;
        intf.in_data  = w;
        while (!intf.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!intf.in_ready)
            check_val("send_timeout", 256'(intf.in_ready), 256'd1);
        @(posedge clk); #1;
        intf.in_valid = 1'b0;
        intf.in_data  = 32'h0;
    endtask

    task automatic recv_line(input string tag, input logic [255:0] exp);
        int n = 0;
        while (!intf.diff_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_valid"}, 256'(intf.diff_valid), 256'd1);
        check_val({tag, "_data"}, intf.diff_o, exp);
        intf.diff_ready = 1'b1;
        @(posedge clk); #1;
        intf.diff_ready = 1'b0;
        check_val({tag, "_done"}, 256'(intf.diff_valid), 256'd0);
        check_val({tag, "_rdy"}, 256'(intf.in_ready), 256'd1);
    endtask

    logic [255:0] l8;
    logic [287:0] s8;
    logic [255:0] hold;

    initial begin
        intf.in_valid   = 1'b0;
        intf.in_data    = 32'h0;
        intf.diff_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 256'(intf.in_ready), 256'd0);
        check_val("rst_diff_valid", 256'(intf.diff_valid), 256'd0);
        check_val("rst_diff_o", intf.diff_o, 256'h0);
        check_val("rst_err", 256'(intf.err_o), 256'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("post_rst_ready", 256'(intf.in_ready), 256'd1);

        // W=0: one word, line of zeros, valid right after the transfer
        send_word(32'h0000_0000);
        check_val("w0_latency", 256'(intf.diff_valid), 256'd1);
        check_val("w0_in_ready", 256'(intf.in_ready), 256'd0);
        recv_line("w0", 256'h0);

        // W=1: all-ones symbols sign-extend to 8'hFF
        send_word(32'h1FFF_FFFF);
        send_word(32'hF000_0000);
        recv_line("w1", {32{8'hFF}});

        // W=8: bytes 00..1F, with an idle gap on the input mid-line
        l8 = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
        s8 = {4'h8, l8, 28'h0};
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                repeat (3) @(posedge clk);
                #1;
                check_val("w8_gap_valid", 256'(intf.diff_valid), 256'd0);
            end
            send_word(s8[287 - 32*i -: 32]);
        end
        check_val("w8_latency", 256'(intf.diff_valid), 256'd1);
        recv_line("w8", l8);

        // W=4: alternating 7 / 8 -> 07 / F8, held under backpressure
        send_word(32'h4787_8787);
        send_word(32'h8787_8787);
        send_word(32'h8787_8787);
        send_word(32'h8787_8787);
        send_word(32'h8000_0000);
        hold = {16{16'h07F8}};
        intf.in_valid = 1'b1;
        intf.in_data  = 32'h9123_4567;   // must be ignored while in_ready=0
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_val("bp_diff_o", intf.diff_o, hold);
            check_val("bp_in_ready", 256'(intf.in_ready), 256'd0);
        end
        intf.in_valid = 1'b0;
        recv_line("w4", hold);
        check_val("bp_err", 256'(intf.err_o), 256'd0);

        // Illegal header W=12: error, no line, next word is a header
        send_word(32'hC000_0000);
        check_val("bad_err", 256'(intf.err_o), 256'd1);
        check_val("bad_valid", 256'(intf.diff_valid), 256'd0);
        check_val("bad_ready", 256'(intf.in_ready), 256'd1);
        send_word(32'h0000_0000);
        check_val("after_bad_valid", 256'(intf.diff_valid), 256'd1);
        recv_line("after_bad", 256'h0);
        check_val("err_sticky", 256'(intf.err_o), 256'd1);

        // Reset mid-COLLECT discards the partial line
        send_word(32'h4787_8787);
        send_word(32'h8787_8787);
        rst = 1'b1;
        #2;
        check_val("mid_rst_ready", 256'(intf.in_ready), 256'd0);
        check_val("mid_rst_valid", 256'(intf.diff_valid), 256'd0);
        check_val("mid_rst_diff_o", intf.diff_o, 256'h0);
        check_val("mid_rst_err", 256'(intf.err_o), 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("mid_rst_ready_after", 256'(intf.in_ready), 256'd1);
        send_word(32'h1FFF_FFFF);
        send_word(32'hF000_0000);
        recv_line("after_rst", {32{8'hFF}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
